// File: rtl/card_pile_manager.sv
// card_pile_manager: draw/discard pile engine with LFSR Fisher-Yates shuffle and streamed deals
//   i_clk, i_rst_n               clock, async active-low reset
//   i_cmd_valid, i_cmd           command strobe/opcode (0 LOAD, 1 DISCARD, 2 DRAW, 3 SHUFFLE)
//   i_card, i_num                card for LOAD/DISCARD, count for DRAW
//   i_seed_valid, i_seed         LFSR reseed (zero seed ignored)
//   o_ready                      idle, command can be accepted
//   o_card_valid, o_card         dealt card stream
//   o_short, o_err               deal ran dry / rejected command pulses
//   o_draw_cnt, o_disc_cnt       pile sizes
//   o_top_disc                   discard top, 0 when empty
module card_pile_manager #(
  parameter int CARD_W = 6,
  parameter int DEPTH = 108,
  parameter int MAX_DRAW = 4,
  parameter int LFSR_W = 8,
  parameter logic [LFSR_W-1:0] SEED = 8'hA5,
  parameter logic [LFSR_W-1:0] TAPS = 8'hB8
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_cmd_valid,
  input  logic [1:0]                      i_cmd,
  input  logic [CARD_W-1:0]               i_card,
  input  logic [$clog2(MAX_DRAW+1)-1:0]   i_num,
  input  logic                            i_seed_valid,
  input  logic [LFSR_W-1:0]               i_seed,
  output logic                            o_ready,
  output logic                            o_card_valid,
  output logic [CARD_W-1:0]               o_card,
  output logic                            o_short,
  output logic                            o_err,
  output logic [$clog2(DEPTH+1)-1:0]      o_draw_cnt,
  output logic [$clog2(DEPTH+1)-1:0]      o_disc_cnt,
  output logic [CARD_W-1:0]               o_top_disc
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  localparam int NW = $clog2(MAX_DRAW+1);
  localparam logic [CW:0] FULL = (CW+1)'(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_RECYCLE, S_SHUFFLE} state_e;
  state_e state_q, state_d, ret_q, ret_d;
  logic [CW-1:0] draw_cnt_q, draw_cnt_d, disc_cnt_q, disc_cnt_d;
  logic [NW-1:0] rem_q, rem_d;
  logic [IW-1:0] idx_q, idx_d, j_q, j_d;
  logic [LFSR_W-1:0] lfsr_q;
  logic err_q, err_d;
  logic [CARD_W-1:0] draw_q [DEPTH];
  logic [CARD_W-1:0] disc_q [DEPTH];
  logic dw_a, dw_b, xw;
  logic [IW-1:0] da_a, da_b, xa, mask, r, draw_top, disc_top;
  logic [CARD_W-1:0] dd_a, dd_b, xd;
  logic full, card_valid, short_p;
  assign full = ({1'b0, draw_cnt_q} + {1'b0, disc_cnt_q}) == FULL;
  assign draw_top = IW'(draw_cnt_q - CW'(1));
  assign disc_top = IW'(disc_cnt_q - CW'(1));
  // Smear the shuffle index right to get the smallest all-ones mask covering it
  always_comb begin
    mask = idx_q;
    for (int k = 1; k < IW; k++) mask = mask | (idx_q >> k);
  end
  assign r = lfsr_q[IW-1:0] & mask;
  always_comb begin
    state_d = state_q;
    ret_d = ret_q;
    draw_cnt_d = draw_cnt_q;
    disc_cnt_d = disc_cnt_q;
    rem_d = rem_q;
    idx_d = idx_q;
    j_d = j_q;
    err_d = 1'b0;
    card_valid = 1'b0;
    short_p = 1'b0;
    dw_a = 1'b0;
    da_a = IW'(draw_cnt_q);
    dd_a = i_card;
    dw_b = 1'b0;
    da_b = r;
    dd_b = draw_q[idx_q];
    xw = 1'b0;
    xa = IW'(disc_cnt_q);
    xd = i_card;
    case (state_q)
      S_IDLE: if (i_cmd_valid) begin
        case (i_cmd)
          2'd0, 2'd1: begin
            err_d = full;
            dw_a = !full && i_cmd == 2'd0;
            xw = !full && i_cmd == 2'd1;
            draw_cnt_d = dw_a ? draw_cnt_q + CW'(1) : draw_cnt_q;
            disc_cnt_d = xw ? disc_cnt_q + CW'(1) : disc_cnt_q;
          end
          2'd2: begin
            err_d = i_num == '0 || i_num > NW'(MAX_DRAW);
            rem_d = i_num;
            state_d = err_d ? S_IDLE : S_DRAW;
          end
          default: if (draw_cnt_q > CW'(1)) begin
            idx_d = draw_top;
            ret_d = S_IDLE;
            state_d = S_SHUFFLE;
          end
        endcase
      end
      S_DRAW: begin
        if (draw_cnt_q != '0) begin
          card_valid = 1'b1;
          draw_cnt_d = draw_cnt_q - CW'(1);
          rem_d = rem_q - NW'(1);
          state_d = rem_q == NW'(1) ? S_IDLE : S_DRAW;
        end else if (disc_cnt_q > CW'(1)) begin
          j_d = '0;
          state_d = S_RECYCLE;
        end else begin
          short_p = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RECYCLE: begin
        dw_a = 1'b1;
        dd_a = disc_q[j_q];
        draw_cnt_d = draw_cnt_q + CW'(1);
        j_d = j_q + IW'(1);
        // Last move also relocates the kept top card down to slot 0
        if (CW'(j_q) == disc_cnt_q - CW'(2)) begin
          xw = 1'b1;
          xa = '0;
          xd = disc_q[disc_top];
          disc_cnt_d = CW'(1);
          idx_d = IW'(draw_cnt_q);
          ret_d = S_DRAW;
          state_d = S_SHUFFLE;
        end
      end
      default: begin
        if (idx_q == '0) state_d = ret_q;
        else if (r <= idx_q) begin
          dw_a = 1'b1;
          da_a = idx_q;
          dd_a = draw_q[r];
          dw_b = 1'b1;
          idx_d = idx_q - IW'(1);
          state_d = idx_q == IW'(1) ? ret_q : S_SHUFFLE;
        end
      end
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ret_q <= S_IDLE;
      draw_cnt_q <= '0;
      disc_cnt_q <= '0;
      rem_q <= '0;
      idx_q <= '0;
      j_q <= '0;
      err_q <= 1'b0;
      lfsr_q <= SEED;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      draw_cnt_q <= draw_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      rem_q <= rem_d;
      idx_q <= idx_d;
      j_q <= j_d;
      err_q <= err_d;
      lfsr_q <= (i_seed_valid && i_seed != '0) ? i_seed : (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end
  end
  // Pile storage needs no reset: counts define which entries are live
  always_ff @(posedge i_clk) begin
    if (dw_a) draw_q[da_a] <= dd_a;
    if (dw_b) draw_q[da_b] <= dd_b;
    if (xw) disc_q[xa] <= xd;
  end
  assign o_ready = state_q == S_IDLE;
  assign o_card_valid = card_valid;
  assign o_card = card_valid ? draw_q[draw_top] : '0;
  assign o_short = short_p;
  assign o_err = err_q;
  assign o_draw_cnt = draw_cnt_q;
  assign o_disc_cnt = disc_cnt_q;
  assign o_top_disc = disc_cnt_q == '0 ? '0 : disc_q[disc_top];
endmodule

// File: tb/tb_card_pile_manager.sv
// tb_card_pile_manager: directed table-driven and sequence checks for card_pile_manager
module tb_card_pile_manager;
  logic i_clk = 0, i_rst_n = 0, i_cmd_valid = 0, i_seed_valid = 0;
  logic [1:0] i_cmd = 0;
  logic [5:0] i_card = 0;
  logic [2:0] i_num = 0;
  logic [7:0] i_seed = 0;
  logic o_ready, o_card_valid, o_short, o_err;
  logic [5:0] o_card, o_top_disc;
  logic [6:0] o_draw_cnt, o_disc_cnt;
  localparam logic [1:0] LOAD = 2'd0, DISC = 2'd1, DRAW = 2'd2, SHUF = 2'd3;
  card_pile_manager dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .i_card(i_card), .i_num(i_num), .i_seed_valid(i_seed_valid), .i_seed(i_seed),
    .o_ready(o_ready), .o_card_valid(o_card_valid), .o_card(o_card), .o_short(o_short),
    .o_err(o_err), .o_draw_cnt(o_draw_cnt), .o_disc_cnt(o_disc_cnt), .o_top_disc(o_top_disc)
  );
  always #5 i_clk = ~i_clk;
  int checks = 0, failures = 0;
  typedef struct {
    logic [1:0] cmd;
    logic [5:0] card;
    logic [2:0] num;
    logic err;
    int dcnt;
    int xcnt;
    logic [5:0] top;
  } vec_t;
  vec_t vt [9];
  logic [5:0] ord [52];
  logic [5:0] first [52];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [1:0] c, input logic [5:0] cd, input logic [2:0] n);
    i_cmd_valid = 1;
    i_cmd = c;
    i_card = cd;
    i_num = n;
    @(negedge i_clk);
    i_cmd_valid = 0;
  endtask
  task automatic do_reset;
    i_rst_n = 0;
    i_cmd_valid = 0;
    i_seed_valid = 0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1;
    @(negedge i_clk);
  endtask
  task automatic shuffle_run;
    int n, bad;
    do_reset;
    i_seed_valid = 1;
    i_seed = 8'h3C;
    @(negedge i_clk);
    i_seed_valid = 0;
    for (int k = 0; k < 52; k++) issue(LOAD, 6'(k), 0);
    for (int s = 0; s < 4; s++) begin
      issue(SHUF, 0, 0);
      n = 0;
      while (!o_ready && n < 2000) begin
        @(negedge i_clk);
        n++;
      end
      chk("shuffle_done", o_ready, 1);
    end
    chk("shuffle_cnt", o_draw_cnt, 52);
    bad = 0;
    for (int d = 0; d < 13; d++) begin
      issue(DRAW, 0, 4);
      for (int c = 0; c < 4; c++) begin
        if (!o_card_valid) bad++;
        ord[d*4+c] = o_card;
        @(negedge i_clk);
      end
    end
    chk("shuffle_deal_valid_misses", bad, 0);
    chk("shuffle_empty_after", o_draw_cnt, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n, nv, ns, bad, nd;
    int seen [52];
    logic [5:0] got [3];
    vt[0] = '{LOAD, 6'h01, 3'd0, 1'b0, 1, 0, 6'h00};
    vt[1] = '{LOAD, 6'h02, 3'd0, 1'b0, 2, 0, 6'h00};
    vt[2] = '{LOAD, 6'h03, 3'd0, 1'b0, 3, 0, 6'h00};
    vt[3] = '{LOAD, 6'h04, 3'd0, 1'b0, 4, 0, 6'h00};
    vt[4] = '{LOAD, 6'h05, 3'd0, 1'b0, 5, 0, 6'h00};
    vt[5] = '{DRAW, 6'h00, 3'd0, 1'b1, 5, 0, 6'h00};
    vt[6] = '{DRAW, 6'h00, 3'd5, 1'b1, 5, 0, 6'h00};
    vt[7] = '{DISC, 6'h2A, 3'd0, 1'b0, 5, 1, 6'h2A};
    vt[8] = '{DISC, 6'h15, 3'd0, 1'b0, 5, 2, 6'h15};
    do_reset;
    chk("rst_draw_cnt", o_draw_cnt, 0);
    chk("rst_disc_cnt", o_disc_cnt, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_card_valid", o_card_valid, 0);
    chk("rst_card", o_card, 0);
    chk("rst_top", o_top_disc, 0);
    chk("rst_err", o_err, 0);
    chk("rst_short", o_short, 0);
    for (int i = 0; i < 9; i++) begin
      issue(vt[i].cmd, vt[i].card, vt[i].num);
      chk($sformatf("vec%0d_err", i), o_err, vt[i].err);
      chk($sformatf("vec%0d_draw_cnt", i), o_draw_cnt, vt[i].dcnt);
      chk($sformatf("vec%0d_disc_cnt", i), o_disc_cnt, vt[i].xcnt);
      chk($sformatf("vec%0d_top", i), o_top_disc, vt[i].top);
    end
    issue(DRAW, 0, 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("draw3_valid%0d", k), o_card_valid, 1);
      chk($sformatf("draw3_card%0d", k), o_card, 5 - k);
      @(negedge i_clk);
    end
    chk("draw3_valid_end", o_card_valid, 0);
    chk("draw3_ready_end", o_ready, 1);
    chk("draw3_draw_cnt", o_draw_cnt, 2);
    do_reset;
    for (int k = 0; k < 108; k++) issue(LOAD, 6'(k), 0);
    chk("full_last_err", o_err, 0);
    chk("full_draw_cnt", o_draw_cnt, 108);
    issue(LOAD, 6'h3F, 0);
    chk("full_load_err", o_err, 1);
    chk("full_load_cnt", o_draw_cnt, 108);
    @(negedge i_clk);
    chk("full_err_pulse", o_err, 0);
    issue(DISC, 6'h3F, 0);
    chk("full_disc_err", o_err, 1);
    chk("full_disc_cnt", o_disc_cnt, 0);
    do_reset;
    issue(LOAD, 6'h30, 0);
    issue(DISC, 6'h11, 0);
    issue(DISC, 6'h12, 0);
    issue(DISC, 6'h13, 0);
    issue(DRAW, 0, 3);
    n = 0;
    nv = 0;
    ns = 0;
    while (!o_ready && n < 100) begin
      if (o_card_valid) begin
        if (nv < 3) got[nv] = o_card;
        nv++;
      end
      if (o_short) ns++;
      @(negedge i_clk);
      n++;
    end
    chk("recyc_done", o_ready, 1);
    chk("recyc_cards", nv, 3);
    chk("recyc_first", got[0], 6'h30);
    chk("recyc_pair", ({got[1], got[2]} == {6'h11, 6'h12}) || ({got[1], got[2]} == {6'h12, 6'h11}), 1);
    chk("recyc_short", ns, 0);
    chk("recyc_disc_cnt", o_disc_cnt, 1);
    chk("recyc_top", o_top_disc, 6'h13);
    chk("recyc_draw_cnt", o_draw_cnt, 0);
    do_reset;
    issue(DISC, 6'h20, 0);
    issue(DRAW, 0, 2);
    chk("short_pulse", o_short, 1);
    chk("short_valid", o_card_valid, 0);
    @(negedge i_clk);
    chk("short_ready", o_ready, 1);
    chk("short_pulse_end", o_short, 0);
    chk("short_valid_end", o_card_valid, 0);
    chk("short_disc_cnt", o_disc_cnt, 1);
    shuffle_run;
    for (int k = 0; k < 52; k++) begin
      first[k] = ord[k];
      seen[k] = 0;
    end
    bad = 0;
    nd = 0;
    for (int k = 0; k < 52; k++) begin
      if (ord[k] < 52) seen[ord[k]]++;
      else bad++;
      if (ord[k] != 6'(51 - k)) nd++;
    end
    for (int k = 0; k < 52; k++) if (seen[k] != 1) bad++;
    chk("shuffle_multiset_bad", bad, 0);
    chk("shuffle_order_changed", nd != 0, 1);
    shuffle_run;
    nd = 0;
    for (int k = 0; k < 52; k++) if (ord[k] != first[k]) nd++;
    chk("shuffle_repro_diffs", nd, 0);
    do_reset;
    for (int k = 0; k < 20; k++) issue(LOAD, 6'(k), 0);
    issue(DISC, 6'h07, 0);
    issue(SHUF, 0, 0);
    repeat (3) @(negedge i_clk);
    chk("midrst_busy", o_ready, 0);
    i_rst_n = 0;
    #1;
    chk("midrst_draw_cnt", o_draw_cnt, 0);
    chk("midrst_disc_cnt", o_disc_cnt, 0);
    chk("midrst_ready", o_ready, 1);
    chk("midrst_valid", o_card_valid, 0);
    @(negedge i_clk);
    chk("midrst_hold_ready", o_ready, 1);
    chk("midrst_hold_valid", o_card_valid, 0);
    chk("midrst_hold_cnt", o_draw_cnt, 0);
    i_rst_n = 1;
    @(negedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
